// File: rtl/scpad_tile_sequencer.sv
// scpad_tile_sequencer
//   Issue stage in front of the scratchpad swizzle/xbar path. Accepts one tile
//   request (base row, tile dims, row/col-major, tag) and emits one beat per
//   handshake carrying the per-beat swizzle inputs.
//
// Handshake rule (both interfaces): a transfer happens on a rising CLK edge
// where valid && ready are both high. A producer holds valid and its payload
// stable until the transfer. Only flush or reset can withdraw beat_valid.
//
// Ports
//   CLK, nRST          clock, async active-low reset
//   flush              synchronous abort of the in-flight tile
//   req_*              tile request (req_ready is the only combinational output)
//   beat_*             per-beat swizzle inputs, registered
//   done / done_id     one-cycle completion pulse with the tile's tag
//   err                one-cycle pulse for an accepted but illegal request
//   state_dbg          current FSM state (0 = IDLE, 1 = ISSUE)
module scpad_tile_sequencer #(
  parameter int NUM_ROWS      = 1024,
  parameter int NUM_COLS      = 32,
  parameter int ROW_IDX_WIDTH = $clog2(NUM_ROWS),
  parameter int COL_IDX_WIDTH = $clog2(NUM_COLS),
  parameter int ID_WIDTH      = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_row_or_col,
  input  logic [ROW_IDX_WIDTH-1:0] req_spad_addr,
  input  logic [COL_IDX_WIDTH:0]   req_num_rows,
  input  logic [COL_IDX_WIDTH:0]   req_num_cols,
  input  logic [ID_WIDTH-1:0]      req_id,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic                     beat_row_or_col,
  output logic [ROW_IDX_WIDTH-1:0] beat_spad_addr,
  output logic [COL_IDX_WIDTH-1:0] beat_row_id,
  output logic [COL_IDX_WIDTH-1:0] beat_col_id,
  output logic [COL_IDX_WIDTH:0]   beat_num_rows,
  output logic [COL_IDX_WIDTH:0]   beat_num_cols,
  output logic                     beat_last,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic                     done,
  output logic [ID_WIDTH-1:0]      done_id,
  output logic                     err,
  output logic                     state_dbg
);

  localparam int CW = COL_IDX_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic                     roc_q, roc_d;
  logic [ROW_IDX_WIDTH-1:0] addr_q, addr_d;
  logic [COL_IDX_WIDTH-1:0] row_id_q, row_id_d;
  logic [COL_IDX_WIDTH-1:0] col_id_q, col_id_d;
  logic [CW-1:0]            nrows_q, nrows_d;
  logic [CW-1:0]            ncols_q, ncols_d;
  logic                     last_q, last_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic                     done_q, done_d;
  logic [ID_WIDTH-1:0]      done_id_q, done_id_d;
  logic                     err_q, err_d;

  logic                     beat_hs;
  logic                     accept;
  logic                     req_legal;
  logic [CW-1:0]            req_count;
  logic [CW-1:0]            cur_count;
  logic [COL_IDX_WIDTH-1:0] iter;
  logic [COL_IDX_WIDTH-1:0] iter_nxt;

  assign beat_hs   = valid_q && beat_ready;
  // A new tile may be taken when idle, or in the same cycle the current
  // tile's last beat leaves, which gives zero-bubble back-to-back tiles.
  assign req_ready = !flush && ((state_q == IDLE) || (beat_hs && last_q));
  assign accept    = req_valid && req_ready;

  assign req_legal = (req_num_rows != '0) && (req_num_cols != '0) &&
                     (req_num_rows <= CW'(NUM_COLS)) &&
                     (req_num_cols <= CW'(NUM_COLS));
  assign req_count = req_row_or_col ? req_num_rows : req_num_cols;

  // Only one of row_id/col_id moves for a given tile; it is the iterator.
  assign cur_count = roc_q ? nrows_q : ncols_q;
  assign iter      = roc_q ? row_id_q : col_id_q;
  assign iter_nxt  = iter + 1'b1;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    roc_d     = roc_q;
    addr_d    = addr_q;
    row_id_d  = row_id_q;
    col_id_d  = col_id_q;
    nrows_d   = nrows_q;
    ncols_d   = ncols_q;
    last_d    = last_q;
    id_d      = id_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    err_d     = 1'b0;

    if (flush) begin
      // The tile is dropped without a completion pulse.
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      if (beat_hs) begin
        if (last_q) begin
          valid_d   = 1'b0;
          state_d   = IDLE;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          if (roc_q) row_id_d = iter_nxt;
          else       col_id_d = iter_nxt;
          last_d = ({1'b0, iter_nxt} == (cur_count - CW'(1)));
        end
      end
      // Applied after the handshake so a tile accepted on the last beat
      // overrides the return to IDLE.
      if (accept) begin
        if (req_legal) begin
          state_d  = ISSUE;
          valid_d  = 1'b1;
          roc_d    = req_row_or_col;
          addr_d   = req_spad_addr;
          row_id_d = '0;
          col_id_d = '0;
          nrows_d  = req_num_rows;
          ncols_d  = req_num_cols;
          last_d   = (req_count == CW'(1));
          id_d     = req_id;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      roc_q     <= 1'b0;
      addr_q    <= '0;
      row_id_q  <= '0;
      col_id_q  <= '0;
      nrows_q   <= '0;
      ncols_q   <= '0;
      last_q    <= 1'b0;
      id_q      <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      roc_q     <= roc_d;
      addr_q    <= addr_d;
      row_id_q  <= row_id_d;
      col_id_q  <= col_id_d;
      nrows_q   <= nrows_d;
      ncols_q   <= ncols_d;
      last_q    <= last_d;
      id_q      <= id_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
    end
  end

  assign beat_valid      = valid_q;
  assign beat_row_or_col = roc_q;
  assign beat_spad_addr  = addr_q;
  assign beat_row_id     = row_id_q;
  assign beat_col_id     = col_id_q;
  assign beat_num_rows   = nrows_q;
  assign beat_num_cols   = ncols_q;
  assign beat_last       = last_q;
  assign beat_id         = id_q;
  assign done            = done_q;
  assign done_id         = done_id_q;
  assign err             = err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_scpad_tile_sequencer.sv
// Testbench for scpad_tile_sequencer: directed scenarios followed by a
// randomized phase, checked against a transaction-level model that expands
// each accepted tile into its list of expected beats.
module tb_scpad_tile_sequencer;

  localparam int BW = 38;  // packed beat: roc,addr,row_id,col_id,nr,nc,last,id

  // Clock / reset
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic       flush = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_row_or_col = 1'b0;
  logic [9:0] req_spad_addr = '0;
  logic [5:0] req_num_rows = '0;
  logic [5:0] req_num_cols = '0;
  logic [3:0] req_id = '0;
  logic       beat_valid;
  logic       beat_ready = 1'b0;
  logic       beat_row_or_col;
  logic [9:0] beat_spad_addr;
  logic [4:0] beat_row_id;
  logic [4:0] beat_col_id;
  logic [5:0] beat_num_rows;
  logic [5:0] beat_num_cols;
  logic       beat_last;
  logic [3:0] beat_id;
  logic       done;
  logic [3:0] done_id;
  logic       err;
  logic       state_dbg;

  scpad_tile_sequencer dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row_or_col(req_row_or_col), .req_spad_addr(req_spad_addr),
    .req_num_rows(req_num_rows), .req_num_cols(req_num_cols), .req_id(req_id),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_row_or_col(beat_row_or_col), .beat_spad_addr(beat_spad_addr),
    .beat_row_id(beat_row_id), .beat_col_id(beat_col_id),
    .beat_num_rows(beat_num_rows), .beat_num_cols(beat_num_cols),
    .beat_last(beat_last), .beat_id(beat_id),
    .done(done), .done_id(done_id), .err(err), .state_dbg(state_dbg)
  );

  logic [BW-1:0] beat_vec;
  assign beat_vec = {beat_row_or_col, beat_spad_addr, beat_row_id, beat_col_id,
                     beat_num_rows, beat_num_cols, beat_last, beat_id};

  // Scoreboard / reference model state
  logic [BW-1:0] exp_q[$];     // remaining beats of the tile on the outputs
  logic          exp_done = 1'b0;
  logic [3:0]    exp_done_id = '0;
  logic          exp_err = 1'b0;
  logic          accepted = 1'b0;
  int            obs_hs = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expand a legal tile into its beat list.
  task automatic push_tile(input logic roc, input logic [9:0] addr,
                           input logic [5:0] nr, input logic [5:0] nc,
                           input logic [3:0] id);
    int cnt;
    logic [4:0] k5;
    cnt = roc ? int'(nr) : int'(nc);
    for (int k = 0; k < cnt; k++) begin
      k5 = 5'(k);
      exp_q.push_back({roc, addr, roc ? k5 : 5'd0, roc ? 5'd0 : k5,
                       nr, nc, (k == cnt - 1), id});
    end
  endtask

  // One clock cycle: entered at posedge+1 with inputs already driven; checks
  // the outputs, advances the model across the next edge, returns at posedge+1.
  task automatic cycle();
    logic mready;
    logic legal;
    logic [BW-1:0] e;
    #1;
    mready = !flush && (exp_q.size() == 0 || (beat_ready && exp_q.size() == 1));
    chk("req_ready", req_ready, mready);
    chk("beat_valid", beat_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("beat", beat_vec, exp_q[0]);
    chk("done", done, exp_done);
    if (exp_done) chk("done_id", done_id, exp_done_id);
    chk("err", err, exp_err);
    if (beat_valid && beat_ready) obs_hs++;

    exp_done = 1'b0;
    exp_err  = 1'b0;
    accepted = 1'b0;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && beat_ready) begin
        e = exp_q.pop_front();
        if (exp_q.size() == 0) begin
          exp_done    = 1'b1;
          exp_done_id = e[3:0];
        end
      end
      if (req_valid && mready) begin
        accepted = 1'b1;
        legal = (req_num_rows >= 1) && (req_num_rows <= 32) &&
                (req_num_cols >= 1) && (req_num_cols <= 32);
        if (legal) push_tile(req_row_or_col, req_spad_addr, req_num_rows, req_num_cols, req_id);
        else exp_err = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send_tile(input logic roc, input logic [9:0] addr,
                           input logic [5:0] nr, input logic [5:0] nc,
                           input logic [3:0] id, output int n);
    req_row_or_col = roc;
    req_spad_addr  = addr;
    req_num_rows   = nr;
    req_num_cols   = nc;
    req_id         = id;
    req_valid      = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 100);
    chk("req_accept", accepted, 1'b1);
    req_valid = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {beat_vec, beat_valid, done, done_id, err, state_dbg};
  endfunction

  initial begin
    int n;
    int hs0;
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int hs0;
    // Reset
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    cycle();

    // Row-major 3-beat tile, always ready
    beat_ready = 1'b1;
    send_tile(1'b1, 10'd5, 6'd3, 6'd8, 4'd2, n);
    chk("first_accept_cycles", n, 1);
    drain(5);

    // Col-major 4-beat tile with ready toggling
    send_tile(1'b0, 10'd0, 6'd32, 6'd4, 4'd7, n);
    hs0 = obs_hs;
    for (int i = 0; i < 14; i++) begin
      beat_ready = (i % 2 == 0);
      cycle();
    end
    beat_ready = 1'b1;
    drain(3);
    chk("colmajor_handshakes", obs_hs - hs0, 4);

    // Back-to-back: B waits through A's two beats, accepted on A's last
    send_tile(1'b1, 10'd10, 6'd2, 6'd4, 4'd3, n);
    send_tile(1'b0, 10'd20, 6'd4, 6'd2, 4'd4, n);
    chk("b2b_accept_cycles", n, 2);
    drain(6);

    // Illegal requests
    send_tile(1'b1, 10'd0, 6'd0, 6'd8, 4'd5, n);
    drain(3);
    send_tile(1'b0, 10'd0, 6'd4, 6'd33, 4'd6, n);
    drain(3);
    send_tile(1'b1, 10'd0, 6'd33, 6'd1, 4'd11, n);
    drain(2);

    // Flush while beat 2 of a 5-beat tile is on the outputs
    send_tile(1'b1, 10'd100, 6'd5, 6'd4, 4'd8, n);
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drain(2);
    send_tile(1'b1, 10'd1020, 6'd2, 6'd4, 4'd9, n);
    drain(4);

    // Flush in idle blocks a request that cycle
    req_row_or_col = 1'b1; req_spad_addr = 10'd1; req_num_rows = 6'd1;
    req_num_cols = 6'd1; req_id = 4'd12; req_valid = 1'b1; flush = 1'b1;
    cycle();
    chk("flush_blocks_accept", accepted, 1'b0);
    flush = 1'b0;
    req_valid = 1'b0;
    drain(2);

    // Single-beat tile
    send_tile(1'b0, 10'd7, 6'd9, 6'd1, 4'd13, n);
    drain(3);

    // Asynchronous reset mid-tile
    send_tile(1'b0, 10'd3, 6'd2, 6'd6, 4'd10, n);
    cycle();
    #2;
    nRST = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (!req_valid || accepted) begin
        req_valid      = ($urandom_range(0, 2) != 0);
        req_row_or_col = $urandom_range(0, 1);
        req_spad_addr  = 10'($urandom_range(0, 1023));
        req_id         = 4'($urandom_range(0, 15));
        req_num_rows   = ($urandom_range(0, 11) == 0) ? 6'($urandom_range(0, 63)) :
                         ($urandom_range(0, 1) == 0) ? 6'($urandom_range(1, 5)) :
                                                        6'($urandom_range(1, 32));
        req_num_cols   = ($urandom_range(0, 11) == 0) ? 6'($urandom_range(0, 63)) :
                         ($urandom_range(0, 1) == 0) ? 6'($urandom_range(1, 5)) :
                                                        6'($urandom_range(1, 32));
      end
      beat_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0;
    req_valid = 1'b0;
    beat_ready = 1'b1;
    drain(40);
    chk("drained_idle", beat_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
